// File: rtl/decoder_pkg.sv
// Shared decode types and helpers for the 2-to-4 select decoder.
// Used by decoder_2to4 and its optional one-hot checker.
package decoder_pkg;

    localparam int SEL_W = 2;
    localparam int OUT_N = 4;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [OUT_N-1:0] dec_t;

    // Enable gating dominates so an unknown select decodes to zero.
    function automatic dec_t onehot4(sel_t sel, logic en);
        dec_t d;
        d = '0;
        if (en) begin
            unique case (sel)
                2'd0: d = 4'b0001;
                2'd1: d = 4'b0010;
                2'd2: d = 4'b0100;
                2'd3: d = 4'b1000;
            endcase
        end
        return d;
    endfunction

    function automatic logic is_onehot(dec_t d);
        return (d != '0) && ((d & (d - dec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/decoder_2to4_chk.sv
// Sticky one-hot checker watching the decoder output register.
// Tracks violations in a saturating 8-bit counter.
module decoder_2to4_chk
    import decoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  dec_t dout,
    output logic err
);

    logic       en_q;
    logic       viol;
    logic [7:0] viol_cnt;

    // dout now reflects the enable sampled one edge ago, held in en_q.
    always_comb begin
        viol = 1'b0;
        if (en_q) viol = !is_onehot(dout);
        else      viol = |dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            err      <= 1'b0;
            viol_cnt <= 8'd0;
        end else begin
            en_q <= en;
            if (viol) err <= 1'b1;
            if (viol && viol_cnt != 8'hFF)
                viol_cnt <= viol_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/decoder_2to4.sv
// 2-to-4 decoder with enable; OUT_REG selects registered or combinational outputs.
// Define DECODER_2TO4_ONEHOT_CHK_EN to add the sticky err output and checker.
module decoder_2to4
    import decoder_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic dout_3,
    output logic dout_2,
    output logic dout_1,
    output logic dout_0,
    input  logic d_en,
    input  logic din_1,
    input  logic din_0
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    ,
    output logic err
`endif
);

    sel_t sel;
    dec_t dec;
    dec_t dout_q;

    assign sel = {din_1, din_0};
    assign dec = onehot4(sel, d_en);

    generate
        if (OUT_REG != 0) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) dout_q <= '0;
                else        dout_q <= dec;
            end
        end else begin : g_comb
            always_comb dout_q = dec;
        end
    endgenerate

    assign {dout_3, dout_2, dout_1, dout_0} = dout_q;

`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    decoder_2to4_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (d_en),
        .dout  (dout_q),
        .err   (err)
    );
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4 (OUT_REG=1) against a select-index model.
// Exercises err as well when DECODER_2TO4_ONEHOT_CHK_EN is defined.
module tb_decoder_2to4;

    logic clk = 1'b0;
    logic rst_n;
    logic dout_3, dout_2, dout_1, dout_0;
    logic d_en, din_1, din_0;
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    logic err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decoder_2to4 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dout_3 (dout_3),
        .dout_2 (dout_2),
        .dout_1 (dout_1),
        .dout_0 (dout_0),
        .d_en   (d_en),
        .din_1  (din_1),
        .din_0  (din_0)
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
        ,
        .err    (err)
`endif
    );

    function automatic logic [3:0] outs();
        return {dout_3, dout_2, dout_1, dout_0};
    endfunction

    // Reference: output line number equals the select value, as a power of two.
    function automatic logic [3:0] model(bit en, int sel);
        int v;
        v = en ? (1 << sel) : 0;
        return v[3:0];
    endfunction

    task automatic drive(bit en, int sel);
        logic [1:0] s;
        s = sel[1:0];
        @(negedge clk);
        d_en  = en;
        din_1 = s[1];
        din_0 = s[0];
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        d_en  = 1'b1;
        din_1 = 1'b1;
        din_0 = 1'b0;
        #1;
        got = outs();
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_t0 got=%b exp=0000", got);
        end
        repeat (2) @(posedge clk);
        #1;
        got = outs();
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_held got=%b exp=0000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = outs();
        vectors++;
        if (got !== model(1, 2)) begin
            miscompares++;
            $display("FAIL reset_release got=%b exp=%b", got, model(1, 2));
        end
    endtask

    task automatic test_disabled_sweep();
        logic [3:0] got;
        for (int s = 0; s < 4; s++) begin
            drive(0, s);
            @(posedge clk);
            #1;
            got = outs();
            vectors++;
            if (got !== 4'b0000) begin
                miscompares++;
                $display("FAIL disabled sel=%0d got=%b exp=0000", s, got);
            end
        end
        @(negedge clk);
        d_en  = 1'b0;
        din_1 = 1'bx;
        din_0 = 1'bz;
        @(posedge clk);
        #1;
        got = outs();
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL disabled_xz got=%b exp=0000", got);
        end
    endtask

    task automatic test_enabled_sweep();
        logic [3:0] got;
        for (int s = 0; s < 4; s++) begin
            drive(1, s);
            @(posedge clk);
            #1;
            got = outs();
            vectors++;
            if (got !== model(1, s)) begin
                miscompares++;
                $display("FAIL enabled sel=%0d got=%b exp=%b", s, got, model(1, s));
            end
        end
    endtask

    // din_0 toggles every cycle, din_1 every 2, d_en every 4, for 7 cycles.
    task automatic test_toggle();
        logic [3:0] got;
        bit en;
        int sel;
        for (int c = 0; c < 7; c++) begin
            en  = ((c / 4) % 2) == 1;
            sel = c % 4;
            drive(en, sel);
            @(posedge clk);
            #1;
            got = outs();
            vectors++;
            if (got !== model(en, sel)) begin
                miscompares++;
                $display("FAIL toggle cyc=%0d got=%b exp=%b", c, got, model(en, sel));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        bit en;
        int sel;
        for (int i = 0; i < 200; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 3);
            drive(en, sel);
            @(posedge clk);
            #1;
            got = outs();
            vectors++;
            if (got !== model(en, sel)) begin
                miscompares++;
                $display("FAIL random i=%0d en=%0d sel=%0d got=%b exp=%b",
                         i, en, sel, got, model(en, sel));
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] got;
        drive(1, 3);
        @(posedge clk);
        #1;
        got = outs();
        vectors++;
        if (got !== model(1, 3)) begin
            miscompares++;
            $display("FAIL midrst_pre got=%b exp=%b", got, model(1, 3));
        end
        #1 rst_n = 1'b0;
        #1;
        got = outs();
        vectors++;
        if (got !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_drop got=%b exp=0000", got);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        got = outs();
        vectors++;
        if (got !== model(1, 3)) begin
            miscompares++;
            $display("FAIL midrst_reload got=%b exp=%b", got, model(1, 3));
        end
    endtask

`ifdef DECODER_2TO4_ONEHOT_CHK_EN
    task automatic test_checker();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_legal err=%b exp=0", err);
        end
        drive(1, 1);
        @(negedge clk);
        force dut.dout_q = 4'b0011;
        @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL chk_set err=%b exp=1", err);
        end
        @(negedge clk);
        release dut.dout_q;
        for (int s = 0; s < 4; s++) begin
            drive(1, s);
            @(posedge clk);
        end
        #1;
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL chk_sticky err=%b exp=1", err);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL chk_clear err=%b exp=0", err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_disabled_sweep();
        test_enabled_sweep();
        test_toggle();
        test_back_to_back();
        test_mid_reset();
`ifdef DECODER_2TO4_ONEHOT_CHK_EN
        test_checker();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
